// File: rtl/godai_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : godai_trace_capture
// Purpose  : Passive monitor on the core instruction-fetch interface. It pairs
//            each granted fetch address with its returned instruction word,
//            tags the pair with a cycle timestamp and a jump flag, and buffers
//            the records in a show-ahead FIFO drained by a valid/ready sink.
//            Inputs are snooped only; nothing is ever driven back to the fetch
//            interface.
// Ports    : clk, rst_n          clock / synchronous active-low reset
//            enable_i            1 = form records, 0 = track fetches only
//            instr_req_i/gnt_i   snooped request/grant (address push)
//            instr_rvalid_i      snooped read-data valid (address pop)
//            instr_addr_i        snooped fetch address
//            instr_rdata_i       snooped instruction word
//            jump_done_i         core pulse: a jump completed
//            trace_valid_o       FIFO head valid
//            trace_data_o        {jump, ts, addr, instr}
//            trace_ready_i       sink accepts head
//            level_o             FIFO occupancy 0..DEPTH
//            drop_count_o        saturating count of records lost to full FIFO
//            protocol_err_o      sticky fetch-protocol violation
// Revision : 1.0 - initial release
// ============================================================================
module godai_trace_capture #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 16,
  parameter int OUTSTANDING = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable_i,
  input  logic                                        instr_req_i,
  input  logic                                        instr_gnt_i,
  input  logic                                        instr_rvalid_i,
  input  logic [ADDR_WIDTH-1:0]                       instr_addr_i,
  input  logic [DATA_WIDTH-1:0]                       instr_rdata_i,
  input  logic                                        jump_done_i,
  output logic                                        trace_valid_o,
  output logic [1+TS_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] trace_data_o,
  input  logic                                        trace_ready_i,
  output logic [$clog2(DEPTH):0]                      level_o,
  output logic [15:0]                                 drop_count_o,
  output logic                                        protocol_err_o
);

  localparam int REC_W    = 1 + TS_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int AQ_PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int AQ_CNT_W = $clog2(OUTSTANDING + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TS_WIDTH-1:0]   ts_q,       ts_d;
  logic                  jump_pend_q, jump_pend_d;
  logic                  err_q,      err_d;
  logic [15:0]           drop_q,     drop_d;

  logic [ADDR_WIDTH-1:0] aq_mem_q [OUTSTANDING];
  logic [AQ_PTR_W-1:0]   aq_rd_q,    aq_rd_d;
  logic [AQ_PTR_W-1:0]   aq_wr_q,    aq_wr_d;
  logic [AQ_CNT_W-1:0]   aq_cnt_q,   aq_cnt_d;

  logic [REC_W-1:0]      tf_mem_q [DEPTH];
  logic [PTR_W-1:0]      tf_rd_q,    tf_rd_d;
  logic [PTR_W-1:0]      tf_wr_q,    tf_wr_d;
  logic [PTR_W:0]        tf_cnt_q,   tf_cnt_d;
  logic [REC_W-1:0]      last_q,     last_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic             aq_empty, aq_full, aq_push, aq_pop, fetch_gnt;
  logic             tf_empty, tf_full, tf_push, tf_pop;
  logic             rec_form, rec_drop;
  logic [REC_W-1:0] rec;

  always_comb begin
    fetch_gnt = instr_req_i & instr_gnt_i;
    aq_empty  = (aq_cnt_q == '0);
    aq_full   = (aq_cnt_q == AQ_CNT_W'(OUTSTANDING));
    aq_pop    = instr_rvalid_i & ~aq_empty;
    // A simultaneous pop frees the slot the grant needs.
    aq_push   = fetch_gnt & (~aq_full | aq_pop);

    rec_form  = instr_rvalid_i & enable_i & ~aq_empty;
    rec       = {jump_pend_q | jump_done_i, ts_q, aq_mem_q[aq_rd_q], instr_rdata_i};

    tf_empty  = (tf_cnt_q == '0);
    tf_full   = (tf_cnt_q == (PTR_W+1)'(DEPTH));
    tf_pop    = ~tf_empty & trace_ready_i;
    tf_push   = rec_form & (~tf_full | tf_pop);
    rec_drop  = rec_form & tf_full & ~tf_pop;
  end

  always_comb begin
    ts_d        = ts_q + TS_WIDTH'(1);
    err_d       = err_q | (fetch_gnt & aq_full & ~aq_pop) | (instr_rvalid_i & aq_empty);

    jump_pend_d = jump_pend_q;
    if (rec_form) begin
      jump_pend_d = 1'b0;
    end else if (enable_i && jump_done_i) begin
      jump_pend_d = 1'b1;
    end

    drop_d = drop_q;
    if (rec_drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    // Address queue pointers wrap explicitly so OUTSTANDING need not be 2^n.
    aq_rd_d = aq_rd_q;
    if (aq_pop) begin
      aq_rd_d = (aq_rd_q == AQ_PTR_W'(OUTSTANDING - 1)) ? '0 : aq_rd_q + AQ_PTR_W'(1);
    end
    aq_wr_d = aq_wr_q;
    if (aq_push) begin
      aq_wr_d = (aq_wr_q == AQ_PTR_W'(OUTSTANDING - 1)) ? '0 : aq_wr_q + AQ_PTR_W'(1);
    end
    aq_cnt_d = aq_cnt_q;
    if (aq_push && !aq_pop) begin
      aq_cnt_d = aq_cnt_q + AQ_CNT_W'(1);
    end else if (!aq_push && aq_pop) begin
      aq_cnt_d = aq_cnt_q - AQ_CNT_W'(1);
    end

    // Trace FIFO pointers are PTR_W wide, so they wrap modulo DEPTH naturally.
    tf_rd_d  = tf_pop  ? tf_rd_q + PTR_W'(1) : tf_rd_q;
    tf_wr_d  = tf_push ? tf_wr_q + PTR_W'(1) : tf_wr_q;
    tf_cnt_d = tf_cnt_q;
    if (tf_push && !tf_pop) begin
      tf_cnt_d = tf_cnt_q + (PTR_W+1)'(1);
    end else if (!tf_push && tf_pop) begin
      tf_cnt_d = tf_cnt_q - (PTR_W+1)'(1);
    end

    // Remember the departing head so the output holds it while empty.
    last_d = tf_pop ? tf_mem_q[tf_rd_q] : last_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q        <= '0;
      jump_pend_q <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
      aq_rd_q     <= '0;
      aq_wr_q     <= '0;
      aq_cnt_q    <= '0;
      tf_rd_q     <= '0;
      tf_wr_q     <= '0;
      tf_cnt_q    <= '0;
      last_q      <= '0;
    end else begin
      ts_q        <= ts_d;
      jump_pend_q <= jump_pend_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      aq_rd_q     <= aq_rd_d;
      aq_wr_q     <= aq_wr_d;
      aq_cnt_q    <= aq_cnt_d;
      tf_rd_q     <= tf_rd_d;
      tf_wr_q     <= tf_wr_d;
      tf_cnt_q    <= tf_cnt_d;
      last_q      <= last_d;
    end
  end

  // Storage arrays carry data only; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (rst_n && aq_push) begin
      aq_mem_q[aq_wr_q] <= instr_addr_i;
    end
    if (rst_n && tf_push) begin
      tf_mem_q[tf_wr_q] <= rec;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign trace_valid_o  = ~tf_empty;
  assign trace_data_o   = tf_empty ? last_q : tf_mem_q[tf_rd_q];
  assign level_o        = tf_cnt_q;
  assign drop_count_o   = drop_q;
  assign protocol_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_godai_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_godai_trace_capture
// Purpose  : Directed self-checking bench for godai_trace_capture. A second
//            instance with a 4-bit timestamp shares all inputs and is checked
//            only for timestamp wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_godai_trace_capture;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        req, gnt, rvalid, jump, ready;
  logic [31:0] addr, rdata;

  logic        valid,  valid4;
  logic [80:0] data;
  logic [68:0] data4;
  logic [4:0]  level;
  logic [2:0]  level4;
  logic [15:0] drop,   drop4;
  logic        err,    err4;

  int checks   = 0;
  int failures = 0;

  godai_trace_capture u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable),
    .instr_req_i(req), .instr_gnt_i(gnt), .instr_rvalid_i(rvalid),
    .instr_addr_i(addr), .instr_rdata_i(rdata), .jump_done_i(jump),
    .trace_valid_o(valid), .trace_data_o(data), .trace_ready_i(ready),
    .level_o(level), .drop_count_o(drop), .protocol_err_o(err)
  );

  godai_trace_capture #(.TS_WIDTH(4), .DEPTH(4)) u_dut_ts4 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable),
    .instr_req_i(req), .instr_gnt_i(gnt), .instr_rvalid_i(rvalid),
    .instr_addr_i(addr), .instr_rdata_i(rdata), .jump_done_i(jump),
    .trace_valid_o(valid4), .trace_data_o(data4), .trace_ready_i(ready),
    .level_o(level4), .drop_count_o(drop4), .protocol_err_o(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] rec(input logic j, input logic [15:0] t,
                                      input logic [31:0] a, input logic [31:0] d);
    return {j, t, a, d};
  endfunction

  // Advance one cycle; afterwards registered outputs reflect the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 0; gnt = 0; rvalid = 0; jump = 0; ready = 0;
  endtask

  // Ends positioned in cycle c0 (timestamp 0).
  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic set_gnt(input logic on, input logic [31:0] a);
    req = on; gnt = on; addr = a;
  endtask

  task automatic set_rv(input logic on, input logic [31:0] d);
    rvalid = on; rdata = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1; addr = 0; rdata = 0;
    idle();
    rst_n = 0;
    tick();

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_data",  data,  0);
    chk("rst_level", level, 0);
    chk("rst_drop",  drop,  0);
    chk("rst_err",   err,   0);

    // ---------------- 1: single fetch ----------------
    set_gnt(1, 32'h20); tick();                 // c1
    set_gnt(0, 0);      tick();                 // c2
    set_rv(1, 32'h13);  tick();                 // c3
    set_rv(0, 0);
    chk("t1_valid", valid, 1);
    chk("t1_data",  data,  rec(0, 16'd2, 32'h20, 32'h13));
    chk("t1_level", level, 1);
    ready = 1; tick();                          // c4
    ready = 0;
    chk("t1_level_after", level, 0);
    chk("t1_valid_after", valid, 0);

    // ---------------- 2: back-to-back ----------------
    do_reset();
    set_gnt(1, 32'h20); tick();                 // c1
    set_gnt(1, 32'h24); set_rv(1, 32'hA1); tick(); // c2
    set_gnt(0, 0);      set_rv(1, 32'hA2); tick(); // c3
    set_rv(0, 0);
    chk("t2_level", level, 2);
    chk("t2_rec0",  data,  rec(0, 16'd1, 32'h20, 32'hA1));
    ready = 1; tick();                          // c4
    chk("t2_rec1",  data,  rec(0, 16'd2, 32'h24, 32'hA2));
    tick();                                     // c5
    ready = 0;
    chk("t2_level_end", level, 0);
    chk("t2_err", err, 0);

    // ---------------- 3: jump flag ----------------
    do_reset();
    set_gnt(1, 32'h40); tick();                 // c1
    set_gnt(0, 0);
    repeat (4) tick();                          // c5
    jump = 1; tick();                           // c6
    jump = 0;
    repeat (3) tick();                          // c9
    chk("t3_no_rec", level, 0);
    set_rv(1, 32'h67); tick();                  // c10
    set_rv(0, 0);
    chk("t3_jump_rec", data, rec(1, 16'd9, 32'h40, 32'h67));
    ready = 1; set_gnt(1, 32'h44); tick();      // c11
    ready = 0; set_gnt(0, 0); set_rv(1, 32'h93); tick(); // c12
    set_rv(0, 0);
    chk("t3_level", level, 1);
    chk("t3_next_rec", data, rec(0, 16'd11, 32'h44, 32'h93));
    // Disabled: fetch still tracked, jump ignored, no record.
    ready = 1; enable = 0; set_gnt(1, 32'h48); jump = 1; tick(); // c13
    ready = 0; set_gnt(0, 0); jump = 0; set_rv(1, 32'hAA); tick(); // c14
    set_rv(0, 0); enable = 1;
    chk("t3_dis_level", level, 0);
    set_gnt(1, 32'h4C); tick();                 // c15
    set_gnt(0, 0); set_rv(1, 32'hBB); tick();   // c16
    set_rv(0, 0);
    chk("t3_dis_rec", data, rec(0, 16'd15, 32'h4C, 32'hBB));
    chk("t3_err", err, 0);

    // ---------------- 5: protocol violations ----------------
    do_reset();
    set_rv(1, 32'h1); tick();                   // c1
    set_rv(0, 0);
    chk("t5_orphan_err",   err,   1);
    chk("t5_orphan_level", level, 0);
    do_reset();
    chk("t5_err_cleared", err, 0);
    set_gnt(1, 32'h10); tick();                 // c1
    set_gnt(1, 32'h14); tick();                 // c2
    chk("t5_err_ok", err, 0);
    set_gnt(1, 32'h18); tick();                 // c3
    set_gnt(0, 0);
    chk("t5_over_err", err, 1);
    set_rv(1, 32'h1); tick();                   // c4
    set_rv(1, 32'h2); tick();                   // c5
    set_rv(0, 0);
    chk("t5_head0", data, rec(0, 16'd3, 32'h10, 32'h1));
    ready = 1; tick();                          // c6
    ready = 0;
    chk("t5_head1", data, rec(0, 16'd4, 32'h14, 32'h2));
    chk("t5_err_sticky", err, 1);

    // ---------------- 6a: timestamp wrap (4-bit instance) ----------------
    do_reset();
    repeat (13) tick();                         // c13
    set_gnt(1, 32'h30); tick();                 // c14
    set_gnt(1, 32'h34); tick();                 // c15
    set_gnt(0, 0); set_rv(1, 32'h15); tick();   // c16
    set_rv(1, 32'h16); tick();                  // c17
    set_rv(0, 0);
    chk("t6_ts15", 81'(data4), 81'({1'b0, 4'd15, 32'h30, 32'h15}));
    ready = 1; tick();                          // c18
    chk("t6_ts0",  81'(data4), 81'({1'b0, 4'd0, 32'h34, 32'h16}));
    chk("t6_ts16_main", data, rec(0, 16'd16, 32'h34, 32'h16));
    tick();
    ready = 0;

    // ---------------- 4: overflow ----------------
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      set_gnt(c < 20, 32'h100 + 32'(4 * c));
      set_rv(c >= 1, 32'hA000 + 32'(c - 1));
      tick();
    end
    idle();
    chk("t4_level", level, 16);
    chk("t4_drop",  drop,  4);
    ready = 1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_drain%0d", k), data,
          rec(0, 16'(k + 1), 32'h100 + 32'(4 * k), 32'hA000 + 32'(k)));
      tick();
    end
    ready = 0;
    chk("t4_empty", valid, 0);
    chk("t4_drop_hold", drop, 4);

    // ---------------- 6b: reset with buffered records ----------------
    for (int c = 0; c <= 5; c++) begin
      set_gnt(c < 5, 32'h200 + 32'(4 * c));
      set_rv(c >= 1, 32'hB000 + 32'(c));
      tick();
    end
    idle();
    chk("t6_level5", level, 5);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_drop",  drop,  0);
    chk("t6_rst_data",  data,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
